knn_topk_vote: RTL

- Parametrised successor to the single-pair KNN datapath: a streaming K-nearest-neighbour classifier core.
- Software loads one test point, then streams training samples (DIM coordinates + label) with valid/ready.
- The block keeps a sorted list of the K closest samples and computes a majority-vote label.
- Sits behind the KNN peripheral register file, replacing per-pair CPU distance bookkeeping.

---
 rtl/knn_topk_vote.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/knn_topk_vote.sv
// Streaming K-nearest-neighbour classifier: squared-distance pipeline feeding a
// sorted top-K list, followed by a per-class vote count and lowest-label-wins argmax.
module knn_topk_vote #(
  parameter int DATA_W  = 16,
  parameter int DIM     = 2,
  parameter int K       = 4,
  parameter int LABEL_W = 4,
  parameter int N_CLASS = 8,
  parameter int DIST_W  = (DIM > 1) ? 2*DATA_W+2+$clog2(DIM) : 2*DATA_W+2,
  parameter int CNT_W   = $clog2(K+1),
  parameter int IDX_W   = (K > 1) ? $clog2(K) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DIM*DATA_W-1:0]   test_pt,
  input  logic                    train_valid,
  output logic                    train_ready,
  input  logic [DIM*DATA_W-1:0]   train_pt,
  input  logic [LABEL_W-1:0]      train_label,
  input  logic                    train_last,
  output logic                    busy,
  output logic                    done,
  output logic [LABEL_W-1:0]      result_label,
  output logic [CNT_W-1:0]        result_votes,
  output logic [CNT_W-1:0]        nbr_count,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [DIST_W-1:0]       rd_dist,
  output logic [LABEL_W-1:0]      rd_label,
  output logic                    rd_valid
);

  localparam int SQ_W   = 2*DATA_W+2;
  localparam int CLS_W  = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;
  localparam int MAX_N  = (K > N_CLASS) ? K : N_CLASS;
  localparam int STEP_W = (MAX_N > 2) ? $clog2(MAX_N) : 1;
  localparam logic [LABEL_W:0] NCLS = (LABEL_W+1)'(N_CLASS);

  typedef enum logic [2:0] {IDLE, ACCEPT, DRAIN, COUNT, ARGMAX, DONE} state_t;

  state_t                state;
  logic [STEP_W-1:0]     step;
  logic [DIM*DATA_W-1:0] test_q;

  logic                  s1_vld, s2_vld;
  logic [SQ_W-1:0]       sq_n  [DIM];
  logic [SQ_W-1:0]       s1_sq [DIM];
  logic [LABEL_W-1:0]    s1_label, s2_label;
  logic [DIST_W-1:0]     sum_n, s2_sum;

  logic [DIST_W-1:0]     l_dist  [K];
  logic [LABEL_W-1:0]    l_label [K];
  logic [K-1:0]          l_vld;
  logic [DIST_W-1:0]     ins_dist  [K];
  logic [LABEL_W-1:0]    ins_label [K];
  logic [K-1:0]          ins_vld;
  logic                  ins_ok;

  logic [CNT_W-1:0]      votes [N_CLASS];
  logic                  hs;

  assign train_ready = (state == ACCEPT);
  assign hs          = train_valid && train_ready && !start;
  assign busy        = (state != IDLE) && (state != DONE);

  assign rd_dist  = l_dist[rd_idx];
  assign rd_label = l_label[rd_idx];
  assign rd_valid = l_vld[rd_idx];

  always_comb begin
    logic signed [DATA_W:0] diff;
    logic signed [SQ_W-1:0] dx;
    for (int unsigned d = 0; d < DIM; d++) begin
      diff = {train_pt[d*DATA_W+DATA_W-1], train_pt[d*DATA_W +: DATA_W]}
           - {test_q[d*DATA_W+DATA_W-1], test_q[d*DATA_W +: DATA_W]};
      dx = {{(SQ_W-DATA_W-1){diff[DATA_W]}}, diff};
      sq_n[d] = dx * dx;
    end
  end

  always_comb begin
    sum_n = '0;
    for (int unsigned d = 0; d < DIM; d++)
      sum_n = sum_n + DIST_W'(s1_sq[d]);
  end

  // Strict '>' makes an equal-distance newcomer land behind existing entries.
  always_comb begin
    logic placed;
    placed       = !l_vld[0] || (l_dist[0] > s2_sum);
    ins_dist[0]  = placed ? s2_sum   : l_dist[0];
    ins_label[0] = placed ? s2_label : l_label[0];
    ins_vld[0]   = l_vld[0] | placed;
    for (int unsigned i = 1; i < K; i++) begin
      ins_dist[i]  = l_dist[i];
      ins_label[i] = l_label[i];
      ins_vld[i]   = l_vld[i];
      if (placed) begin
        ins_dist[i]  = l_dist[i-1];
        ins_label[i] = l_label[i-1];
        ins_vld[i]   = l_vld[i-1];
      end else if (!l_vld[i] || (l_dist[i] > s2_sum)) begin
        ins_dist[i]  = s2_sum;
        ins_label[i] = s2_label;
        ins_vld[i]   = 1'b1;
        placed       = 1'b1;
      end
    end
    ins_ok = placed;
  end

  always_ff @(posedge clk) begin
    if (hs) begin
      s1_sq    <= sq_n;
      s1_label <= train_label;
    end
    s2_sum   <= sum_n;
    s2_label <= s1_label;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      step         <= '0;
      test_q       <= '0;
      s1_vld       <= 1'b0;
      s2_vld       <= 1'b0;
      done         <= 1'b0;
      result_label <= '0;
      result_votes <= '0;
      nbr_count    <= '0;
      l_vld        <= '0;
      for (int unsigned i = 0; i < K; i++) begin
        l_dist[i]  <= '1;
        l_label[i] <= '0;
      end
      for (int unsigned c = 0; c < N_CLASS; c++)
        votes[c] <= '0;
    end else begin
      done   <= 1'b0;
      s1_vld <= hs;
      s2_vld <= s1_vld;

      if (s2_vld && ins_ok) begin
        l_dist  <= ins_dist;
        l_label <= ins_label;
        l_vld   <= ins_vld;
        if (nbr_count != CNT_W'(K))
          nbr_count <= nbr_count + 1'b1;
      end

      case (state)
        ACCEPT: begin
          if (hs && train_last) begin
            state <= DRAIN;
            step  <= '0;
          end
        end
        DRAIN: begin
          if (step == STEP_W'(1)) begin
            state <= COUNT;
            step  <= '0;
          end else begin
            step <= step + 1'b1;
          end
        end
        COUNT: begin
          if (l_vld[IDX_W'(step)] && ({1'b0, l_label[IDX_W'(step)]} < NCLS))
            votes[CLS_W'(l_label[IDX_W'(step)])] <= votes[CLS_W'(l_label[IDX_W'(step)])] + 1'b1;
          if (step == STEP_W'(K-1)) begin
            state <= ARGMAX;
            step  <= '0;
          end else begin
            step <= step + 1'b1;
          end
        end
        ARGMAX: begin
          if (votes[CLS_W'(step)] > result_votes) begin
            result_votes <= votes[CLS_W'(step)];
            result_label <= LABEL_W'(step);
          end
          if (step == STEP_W'(N_CLASS-1)) begin
            state <= DONE;
            step  <= '0;
            done  <= 1'b1;
          end else begin
            step <= step + 1'b1;
          end
        end
        IDLE, DONE: ;
        default: state <= IDLE;
      endcase

      // Abort has priority over everything in flight, including a pending insertion.
      if (start) begin
        state        <= ACCEPT;
        step         <= '0;
        test_q       <= test_pt;
        s1_vld       <= 1'b0;
        s2_vld       <= 1'b0;
        done         <= 1'b0;
        result_label <= '0;
        result_votes <= '0;
        nbr_count    <= '0;
        l_vld        <= '0;
        for (int unsigned i = 0; i < K; i++) begin
          l_dist[i]  <= '1;
          l_label[i] <= '0;
        end
        for (int unsigned c = 0; c < N_CLASS; c++)
          votes[c] <= '0;
      end
    end
  end

endmodule
